div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle radix-2 divider in the EX stage of the five-stage MIPS pipeline, downstream of the pipeline controller. It consumes the EX-stage divide decode (DIV/DIVU) and register operands, and raises a stall request to the hazard unit while it iterates. It delivers quotient/remainder for the HI/LO write on the cycle the pipeline is released.

## Interface
- WIDTH, 32, operand/result width (state counter sized ceil(log2(WIDTH))+1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  EX-stage instruction is DIV/DIVU (from decoded ALUControlE); held high while EX is stalled
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- a  input  WIDTH  dividend (rs); sampled with start
- b  input  WIDTH  divisor (rt); sampled with start
- flush  input  1  cancel current operation (FlushE or exception)
- stall_req  output  1  stall IF/ID/EX, hold EX/MEM
- valid  output  1  one-cycle pulse, hi/lo hold a fresh result
- hi  output  WIDTH  remainder (registered)
- lo  output  WIDTH  quotient (registered)

## Operation
- States: IDLE, BUSY, DONE.
- IDLE with start=1 and flush=0:
  - Latch |a|, |b|.
  - Latch quotient sign (a[W-1]^b[W-1])&signed_div and remainder sign a[W-1]&signed_div.
  - Clear partial remainder and counter.
  - Go to BUSY; if b==0, go to DONE instead.
- BUSY: one restoring step per cycle.
  - Shift {rem,quo} left 1.
  - Trial subtract rem−|b| at WIDTH+1 bits; if non-negative, keep the difference and set quo LSB.
  - Counter increments; after WIDTH steps go to DONE.
- DONE:
  - Load lo = quotient sign ? −quo : quo.
  - Load hi = remainder sign ? −rem : rem.
  - valid=1 for this cycle only; next state IDLE.
- Divide by zero: DONE directly; lo = all ones, hi = a (unmodified). This is a defined result; no exception.
- Overflow: 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0. The abs of the most-negative value is taken as an unsigned WIDTH-bit value, so this falls out naturally.
- hi/lo are updated only in DONE and hold otherwise.
- stall_req = (IDLE & start & ~flush) | BUSY. It is low in DONE so the pipeline advances on the edge leaving DONE.
- flush in any state: next state IDLE, no valid pulse, hi/lo unchanged. flush has priority over start.
- start seen in DONE is ignored: DONE always returns to IDLE. A back-to-back DIV in the next EX instruction starts from IDLE one cycle later.
- start dropping in BUSY without flush is a protocol violation; the operation completes regardless.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, hi=0, lo=0, valid=0.
  - stall_req=0 while reset is held.
- Latency, nonzero divisor:
  - start sampled at edge k.
  - BUSY covers edges k+1 … k+WIDTH.
  - DONE/valid occupies the cycle after edge k+WIDTH; WIDTH+1 cycles total.
  - With WIDTH=32, valid is seen 33 cycles after the sampling edge.
- Latency, zero divisor: valid in the cycle after edge k.
- stall_req is high combinationally in the cycle start first rises. It stays high through every BUSY cycle and is low in the DONE cycle.
- Reset asserted mid-operation: immediate return to IDLE with reset values; no partial result leaks.
- Throughput: one division per WIDTH+2 cycles back-to-back, counting the IDLE re-entry.

## Test plan
- 100 / 7 unsigned (start held) -> stall_req high 33 cycles, valid pulse once; lo=14, hi=2.
- −7 / 2 signed (0xFFFFFFF9, 0x2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 7 / −2 -> lo=0xFFFFFFFD, hi=1.
- 0x80000000 / 0xFFFFFFFF signed -> lo=0x80000000, hi=0. Same operands unsigned -> lo=0, hi=0x80000000.
- 0x1234 / 0 -> valid one cycle after start, lo=0xFFFFFFFF, hi=0x1234. stall_req low in the valid cycle.
- flush at the 10th BUSY cycle of 50/5 -> IDLE next cycle, no valid, hi/lo keep prior values. A following 50/5 gives lo=10, hi=0 after 33 cycles.
- Two DIVs back-to-back (9/4 then 20/6) -> two valid pulses 34 cycles apart. Results hi=1/lo=2, then hi=2/lo=3. rst pulsed mid-second operation -> hi=lo=0, no valid pulse.

Source files
------------

// File: rtl/div_unit_if.sv
// Pipeline-side bundle for the EX-stage divider: the decoded DIV/DIVU request,
// its operands and the cancel line go in; stall, result-valid and HI/LO come back.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             stall_req;
  logic             valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline controller side
  modport master (
    output start, signed_div, a, b, flush,
    input  stall_req, valid, hi, lo
  );

  // Divider side
  modport slave (
    input  start, signed_div, a, b, flush,
    output stall_req, valid, hi, lo
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage.
// Operands are reduced to magnitudes on acceptance, WIDTH shift/subtract steps
// run one per cycle, and the sign-corrected quotient/remainder land in lo/hi on
// the edge that enters DONE, so hi/lo already hold the fresh result while valid
// is high (the cycle in which the pipeline is released).
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       nextState;
  logic [CW-1:0]    count;

  // Iteration registers: divisor magnitude, partial remainder, and the
  // dividend that turns into the quotient as bits shift out of its top.
  logic [WIDTH-1:0] divisorAbs;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic             quoNeg;
  logic             remNeg;

  // Architectural HI/LO plus the values they held before the latest load,
  // so a flush that lands in the DONE cycle can take the result back.
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic [WIDTH-1:0] hiPrev;
  logic [WIDTH-1:0] loPrev;

  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] aAbs;
  logic [WIDTH-1:0] bAbs;
  logic             divByZero;
  logic             accept;
  logic             lastStep;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] stepRem;
  logic [WIDTH-1:0] stepQuo;
  logic [WIDTH-1:0] resRem;
  logic [WIDTH-1:0] resQuo;

  // Magnitudes: the most-negative value negates to itself, which read as an
  // unsigned WIDTH-bit number is exactly its magnitude.
  assign aNeg      = bus.signed_div & bus.a[WIDTH-1];
  assign bNeg      = bus.signed_div & bus.b[WIDTH-1];
  assign aAbs      = aNeg ? ({WIDTH{1'b0}} - bus.a) : bus.a;
  assign bAbs      = bNeg ? ({WIDTH{1'b0}} - bus.b) : bus.b;
  assign divByZero = (bus.b == {WIDTH{1'b0}});

  // flush outranks start; a new operation is only taken from IDLE.
  assign accept    = (state == IDLE) & bus.start & ~bus.flush;
  assign lastStep  = (count == CW'(WIDTH - 1));

  // One restoring step: shift {rem,quo} left, trial-subtract at WIDTH+1 bits.
  always_comb begin
    partial = {remReg, quoReg[WIDTH-1]};
    trial   = partial - {1'b0, divisorAbs};
    fits    = ~trial[WIDTH];
    stepRem = fits ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
    stepQuo = {quoReg[WIDTH-2:0], fits};
    resQuo  = quoNeg ? ({WIDTH{1'b0}} - stepQuo) : stepQuo;
    resRem  = remNeg ? ({WIDTH{1'b0}} - stepRem) : stepRem;
  end

  // Next-state selection; flush forces IDLE from every state.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          nextState = divByZero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (lastStep) begin
          nextState = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
    if (bus.flush) begin
      nextState = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Operand capture on acceptance, then one iteration per BUSY cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      divisorAbs <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      quoNeg     <= 1'b0;
      remNeg     <= 1'b0;
    end else if (accept) begin
      count      <= '0;
      divisorAbs <= bAbs;
      remReg     <= '0;
      quoReg     <= aAbs;
      quoNeg     <= (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) & bus.signed_div;
      remNeg     <= aNeg;
    end else if (state == BUSY) begin
      count      <= count + CW'(1);
      remReg     <= stepRem;
      quoReg     <= stepQuo;
    end
  end

  // HI/LO: loaded on the edge into DONE, restored if DONE is flushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hiReg  <= '0;
      loReg  <= '0;
      hiPrev <= '0;
      loPrev <= '0;
    end else if (accept && divByZero) begin
      hiPrev <= hiReg;
      loPrev <= loReg;
      hiReg  <= bus.a;
      loReg  <= {WIDTH{1'b1}};
    end else if ((state == BUSY) && lastStep && !bus.flush) begin
      hiPrev <= hiReg;
      loPrev <= loReg;
      hiReg  <= resRem;
      loReg  <= resQuo;
    end else if ((state == DONE) && bus.flush) begin
      hiReg  <= hiPrev;
      loReg  <= loPrev;
    end
  end

  // Stall from the first cycle a DIV sits in EX until the result is ready;
  // it drops in DONE so the pipeline advances on the edge leaving DONE.
  assign bus.stall_req = rst & (((state == IDLE) & bus.start & ~bus.flush) |
                                (state == BUSY));
  assign bus.valid     = (state == DONE) & ~bus.flush;
  assign bus.hi        = hiReg;
  assign bus.lo        = loReg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases with literal results, a
// flush case, back-to-back and mid-operation reset, then randomized traffic.
// A cycle-level reference built from plain arithmetic is compared every cycle.
module tb_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus();

  div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int validCount = 0;
  int cyc = 0;

  // Reference state: committed HI/LO, pending result and its cycle number.
  bit          inFlight = 1'b0;
  int          resultCycle = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  logic [31:0] pHi = '0;
  logic [31:0] pLo = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Returns {remainder, quotient} as the pipeline sees them in HI/LO.
  function automatic logic [63:0] calcRes(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    longint sa, sb, q, r;
    if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
    if (sv) begin
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      q  = sa / sb;
      r  = sa - q * sb;
      return {r[31:0], q[31:0]};
    end
    return {av % bv, av / bv};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: an accepted request finishes WIDTH cycles later (or at once
  // for a zero divisor); flush cancels; the result commits leaving its cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      inFlight <= 1'b0;
      mHi <= '0;
      mLo <= '0;
    end else if (inFlight && cyc == resultCycle) begin
      if (!bus.flush) begin
        mHi <= pHi;
        mLo <= pLo;
      end
      inFlight <= 1'b0;
    end else if (inFlight && bus.flush) begin
      inFlight <= 1'b0;
    end else if (!inFlight && bus.start && !bus.flush) begin
      {pHi, pLo} <= calcRes(bus.a, bus.b, bus.signed_div);
      inFlight <= 1'b1;
      resultCycle <= cyc + 1 + ((bus.b == 32'd0) ? 0 : W);
    end
  end

  // Per-cycle compare against the reference.
  always @(negedge clk) begin
    logic expStall, expValid;
    logic [31:0] eHi, eLo;
    if (inFlight && cyc < resultCycle) begin
      expStall = 1'b1; expValid = 1'b0; eHi = mHi; eLo = mLo;
    end else if (inFlight && cyc == resultCycle) begin
      expStall = 1'b0; expValid = !bus.flush; eHi = pHi; eLo = pLo;
    end else begin
      expStall = rst && bus.start && !bus.flush; expValid = 1'b0; eHi = mHi; eLo = mLo;
    end
    check("stall_req", {31'd0, bus.stall_req}, {31'd0, expStall});
    check("valid", {31'd0, bus.valid}, {31'd0, expValid});
    check("hi", bus.hi, eHi);
    check("lo", bus.lo, eLo);
    if (bus.valid) validCount++;
  end

  // Issue one request (start left high) and wait for its valid pulse.
  task automatic doOp(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                      output int stalls, output int startCyc, output int vCyc);
    bit got;
    bus.start = 1'b1; bus.signed_div = sv; bus.a = av; bus.b = bv;
    stalls = 0; startCyc = cyc; vCyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.stall_req) stalls++;
      got = bus.valid;
      if (got) vCyc = cyc;
      @(posedge clk); #1;
      if (got) break;
    end
    if (vCyc < 0) begin
      checks++; errors++;
      $display("FAIL op_timeout: no valid for 0x%08h / 0x%08h, required within 100 cycles", av, bv);
    end
  endtask

  logic [31:0] tA [6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'h0000_1234};
  logic [31:0] tB [6] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
  logic        tS [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] tLo[6] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
  logic [31:0] tHi[6] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h8000_0000, 32'h0000_1234};

  initial begin
    int stalls, sCyc, vCyc, v0, v1, lat;
    logic [31:0] ra, rb;
    logic rs;
    int gap, flushAt;
    bit got, done;

    // Reset held with a request pending: no stall, all-zero results.
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd100; bus.b = 32'd7; bus.flush = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_valid", {31'd0, bus.valid}, 32'd0);
    check("reset_stall", {31'd0, bus.stall_req}, 32'd0);
    bus.start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed operations with literal results and latency.
    for (int t = 0; t < 6; t++) begin
      v0 = validCount;
      doOp(tA[t], tB[t], tS[t], stalls, sCyc, vCyc);
      bus.start = 1'b0;
      lat = (tB[t] == 32'd0) ? 1 : 33;
      $display("op %0d: 0x%08h / 0x%08h signed=%0d -> lo=0x%08h hi=0x%08h latency=%0d stalls=%0d",
               t, tA[t], tB[t], tS[t], bus.lo, bus.hi, vCyc - sCyc, stalls);
      check("dir_lo", bus.lo, tLo[t]);
      check("dir_hi", bus.hi, tHi[t]);
      check("dir_latency", vCyc - sCyc, lat);
      check("dir_stall_cycles", stalls, lat);
      check("dir_valid_count", validCount - v0, 1);
      @(posedge clk); #1;
    end

    // Flush on the 10th BUSY cycle of 50/5: nothing lands, HI/LO keep 0x1234 / all ones.
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd50; bus.b = 32'd5;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_to_idle", {31'd0, bus.stall_req}, 32'd0);
    v0 = validCount;
    repeat (40) @(posedge clk);
    #1;
    check("flush_no_valid", validCount - v0, 0);
    check("flush_hi_kept", bus.hi, 32'h0000_1234);
    check("flush_lo_kept", bus.lo, 32'hFFFF_FFFF);
    doOp(32'd50, 32'd5, 1'b0, stalls, sCyc, vCyc);
    bus.start = 1'b0;
    $display("op after flush: 50 / 5 -> lo=%0d hi=%0d latency=%0d", bus.lo, bus.hi, vCyc - sCyc);
    check("refire_lo", bus.lo, 32'd10);
    check("refire_hi", bus.hi, 32'd0);
    check("refire_latency", vCyc - sCyc, 33);
    @(posedge clk); #1;

    // Back-to-back with start held: pulses 34 cycles apart.
    doOp(32'd9, 32'd4, 1'b0, stalls, sCyc, v1);
    check("b2b_first_lo", bus.lo, 32'd2);
    check("b2b_first_hi", bus.hi, 32'd1);
    doOp(32'd20, 32'd6, 1'b0, stalls, sCyc, vCyc);
    bus.start = 1'b0;
    $display("back-to-back: 9/4 then 20/6 -> lo=%0d hi=%0d spacing=%0d", bus.lo, bus.hi, vCyc - v1);
    check("b2b_second_lo", bus.lo, 32'd3);
    check("b2b_second_hi", bus.hi, 32'd2);
    check("b2b_spacing", vCyc - v1, 34);
    @(posedge clk); #1;

    // Reset mid-operation: immediate zeros, no pulse afterwards.
    bus.start = 1'b1; bus.a = 32'd20; bus.b = 32'd6;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    $display("mid-op reset: lo=0x%08h hi=0x%08h valid=%0d stall=%0d", bus.lo, bus.hi, bus.valid, bus.stall_req);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    check("midrst_valid", {31'd0, bus.valid}, 32'd0);
    check("midrst_stall", {31'd0, bus.stall_req}, 32'd0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    v0 = validCount;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_valid", validCount - v0, 0);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int n = 0; n < 150; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      #0;
      ra = $urandom;
      if ($urandom % 10 == 0) ra = 32'h8000_0000;
      case ($urandom % 6)
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFF_FFFF;
        3: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      rs = 1'($urandom % 2);
      flushAt = ($urandom % 8 == 0) ? $urandom_range(0, 35) : -1;
      bus.start = 1'b1; bus.signed_div = rs; bus.a = ra; bus.b = rb;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
        if (i == flushAt) begin
          bus.flush = 1'b1; bus.start = 1'b0;
          @(posedge clk); #1;
          bus.flush = 1'b0;
          done = 1'b1;
        end else begin
          @(negedge clk);
          got = bus.valid;
          @(posedge clk); #1;
          if (got) begin
            bus.start = 1'b0;
            done = 1'b1;
          end
        end
      end
      $display("rand %0d: 0x%08h / 0x%08h signed=%0d flushAt=%0d -> lo=0x%08h hi=0x%08h",
               n, ra, rb, rs, flushAt, bus.lo, bus.hi);
      if (!done) begin
        checks++; errors++;
        $display("FAIL rand_timeout: op %0d never completed, required within 60 cycles", n);
        bus.start = 1'b0;
      end
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
